dm_sram_axi_slave: RTL

AXI4 responder that fronts the single-port data-memory SRAM macro on the SoC bus. It accepts single-beat writes and INCR read bursts from bus masters through the interconnect slave port, and serialises them onto one SRAM port with 1-cycle read latency. Reads and writes share the macro, so one transaction is in service at a time.

---
 rtl/dm_sram_axi_slave_pkg.sv | 28 ++
 rtl/dm_sram_axi_slave_if.sv | 74 +++++++
 rtl/dm_sram_axi_slave_wstrb2bweb.sv | 17 +
 rtl/dm_sram_axi_slave.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_sram_axi_slave_pkg.sv
// Shared types and constants for the data-memory SRAM AXI responder.
package dm_sram_axi_slave_pkg;

    // Transaction FSM: one address phase is in service at a time.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_R    = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_e;

    // Class of the most recently granted transaction, used for round-robin.
    typedef enum logic {
        SRV_READ  = 1'b0,
        SRV_WRITE = 1'b1
    } serve_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    // Map an error flag onto an AXI response code.
    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/dm_sram_axi_slave_if.sv
// AXI4 slave-side channel bundle for the data-memory SRAM responder.
interface dm_sram_axi_slave_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);

    // Write address channel
    logic [ID_W-1:0]     AWID_S;
    logic [ADDR_W-1:0]   AWADDR_S;
    logic [LEN_W-1:0]    AWLEN_S;
    logic [2:0]          AWSIZE_S;
    logic [1:0]          AWBURST_S;
    logic                AWVALID_S;
    logic                AWREADY_S;

    // Write data channel
    logic [DATA_W-1:0]   WDATA_S;
    logic [DATA_W/8-1:0] WSTRB_S;
    logic                WLAST_S;
    logic                WVALID_S;
    logic                WREADY_S;

    // Write response channel
    logic [ID_W-1:0]     BID_S;
    logic [1:0]          BRESP_S;
    logic                BVALID_S;
    logic                BREADY_S;

    // Read address channel
    logic [ID_W-1:0]     ARID_S;
    logic [ADDR_W-1:0]   ARADDR_S;
    logic [LEN_W-1:0]    ARLEN_S;
    logic [2:0]          ARSIZE_S;
    logic [1:0]          ARBURST_S;
    logic                ARVALID_S;
    logic                ARREADY_S;

    // Read data channel
    logic [ID_W-1:0]     RID_S;
    logic [DATA_W-1:0]   RDATA_S;
    logic [1:0]          RRESP_S;
    logic                RLAST_S;
    logic                RVALID_S;
    logic                RREADY_S;

    modport slave (
        input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        output AWREADY_S,
        input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        output WREADY_S,
        output BID_S, BRESP_S, BVALID_S,
        input  BREADY_S,
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        output ARREADY_S,
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        input  RREADY_S
    );

    modport master (
        output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        input  AWREADY_S,
        output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        input  WREADY_S,
        input  BID_S, BRESP_S, BVALID_S,
        output BREADY_S,
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        input  ARREADY_S,
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        output RREADY_S
    );

endinterface

// File: rtl/dm_sram_axi_slave_wstrb2bweb.sv
// Expands AXI byte strobes into the SRAM per-bit write mask (low = write).
module dm_sram_wstrb2bweb #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   bweb
);

    // Each strobe bit enables (drives low) the eight mask bits of its byte.
    always_comb begin
        bweb = '1;
        for (int unsigned i = 0; i < DATA_W / 8; i++) begin
            bweb[i*8 +: 8] = {8{~wstrb[i]}};
        end
    end

endmodule

// File: rtl/dm_sram_axi_slave.sv
// AXI4 responder in front of the single-port data-memory SRAM macro.
// Serves single-beat/INCR writes and INCR read bursts one at a time,
// round-robin between reads and writes, with 1-cycle SRAM read latency.
// Optional build macro: DM_SLAVE_RESP_CHECK_EN (protocol checks -> SLVERR).
module dm_sram_axi_slave
    import dm_sram_axi_slave_pkg::*;
#(
    parameter int ID_W    = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int SRAM_AW = 14
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    dm_sram_axi_slave_if.slave    axi,
    output logic                  CEB,
    output logic                  WEB,
    output logic [DATA_W-1:0]     BWEB,
    output logic [SRAM_AW-1:0]    A,
    output logic [DATA_W-1:0]     DI,
    input  logic [DATA_W-1:0]     DO
);

    state_e               state_q;
    state_e               state_d;
    serve_e               last_q;
    logic [ID_W-1:0]      id_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     beat_q;
    logic [SRAM_AW-1:0]   addr_q;

    logic                 grant_w;
    logic                 grant_r;
    logic                 aw_hs;
    logic                 ar_hs;
    logic                 r_acc;
    logic                 w_acc;
    logic                 last_beat;
    logic [SRAM_AW-1:0]   ar_word;
    logic [SRAM_AW-1:0]   aw_word;
    logic [DATA_W-1:0]    strb_mask;

    // Size, burst type, WLAST and upper address bits do not steer the default datapath.
    logic                 unused_sink;
    assign unused_sink = &{1'b0, axi.AWADDR_S, axi.ARADDR_S, axi.AWSIZE_S,
                           axi.AWBURST_S, axi.ARSIZE_S, axi.ARBURST_S, axi.WLAST_S};

    assign ar_word   = axi.ARADDR_S[SRAM_AW+1:2];
    assign aw_word   = axi.AWADDR_S[SRAM_AW+1:2];
    assign last_beat = (beat_q == len_q);

    dm_sram_wstrb2bweb #(
        .DATA_W (DATA_W)
    ) u_wstrb2bweb (
        .wstrb (axi.WSTRB_S),
        .bweb  (strb_mask)
    );

    // Round-robin grant: on contention, serve the class not served last.
    always_comb begin
        grant_w = axi.AWVALID_S & (~axi.ARVALID_S | (last_q == SRV_READ));
        grant_r = axi.ARVALID_S & (~axi.AWVALID_S | (last_q == SRV_WRITE));
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, channel handshakes and SRAM port drive.
    always_comb begin
        state_d        = state_q;
        axi.AWREADY_S  = 1'b0;
        axi.ARREADY_S  = 1'b0;
        axi.WREADY_S   = 1'b0;
        axi.BVALID_S   = 1'b0;
        axi.RVALID_S   = 1'b0;
        axi.RLAST_S    = 1'b0;
        CEB            = 1'b1;
        WEB            = 1'b1;
        BWEB           = '1;
        A              = addr_q;
        DI             = '0;
        aw_hs          = 1'b0;
        ar_hs          = 1'b0;
        r_acc          = 1'b0;
        w_acc          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                axi.AWREADY_S = grant_w;
                axi.ARREADY_S = grant_r;
                aw_hs         = grant_w;
                ar_hs         = grant_r;
                if (grant_r) begin
                    // First beat is fetched in the address cycle so data is ready on entry to R.
                    CEB     = 1'b0;
                    A       = ar_word;
                    state_d = ST_R;
                end else if (grant_w) begin
                    state_d = ST_W;
                end
            end

            ST_R: begin
                axi.RVALID_S = 1'b1;
                axi.RLAST_S  = last_beat;
                // While stalled the current word is re-read so DO stays stable.
                CEB          = 1'b0;
                if (axi.RREADY_S) begin
                    r_acc = 1'b1;
                    if (last_beat) begin
                        CEB     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        A = addr_q + 1'b1;
                    end
                end
            end

            ST_W: begin
                axi.WREADY_S = 1'b1;
                if (axi.WVALID_S) begin
                    w_acc = 1'b1;
                    CEB   = 1'b0;
                    WEB   = 1'b0;
                    BWEB  = strb_mask;
                    DI    = axi.WDATA_S;
                    if (last_beat) begin
                        state_d = ST_B;
                    end
                end
            end

            ST_B: begin
                axi.BVALID_S = 1'b1;
                if (axi.BREADY_S) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Transaction context: ID, length, word address, beat count, last-served class.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            last_q <= SRV_READ;
            id_q   <= '0;
            len_q  <= '0;
            beat_q <= '0;
            addr_q <= '0;
        end else if (ar_hs) begin
            last_q <= SRV_READ;
            id_q   <= axi.ARID_S;
            len_q  <= axi.ARLEN_S;
            beat_q <= '0;
            addr_q <= ar_word;
        end else if (aw_hs) begin
            last_q <= SRV_WRITE;
            id_q   <= axi.AWID_S;
            len_q  <= axi.AWLEN_S;
            beat_q <= '0;
            addr_q <= aw_word;
        end else if (r_acc || w_acc) begin
            beat_q <= beat_q + 1'b1;
            addr_q <= addr_q + 1'b1;
        end
    end

    assign axi.BID_S   = id_q;
    assign axi.RID_S   = id_q;
    assign axi.RDATA_S = DO;

`ifdef DM_SLAVE_RESP_CHECK_EN
    logic err_q;
    logic ar_bad;
    logic aw_bad;
    logic wlast_bad;

    // Protocol checks on the address phase and on each accepted write beat.
    always_comb begin
        ar_bad    = (axi.ARBURST_S != BURST_INCR) || (axi.ARSIZE_S != SIZE_WORD);
        aw_bad    = (axi.AWBURST_S != BURST_INCR) || (axi.AWSIZE_S != SIZE_WORD);
        wlast_bad = w_acc && (axi.WLAST_S != last_beat);
    end

    // Error flag is sticky for the life of a transaction and re-armed at each address phase.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_q <= 1'b0;
        end else if (ar_hs) begin
            err_q <= ar_bad;
        end else if (aw_hs) begin
            err_q <= aw_bad;
        end else if (wlast_bad) begin
            err_q <= 1'b1;
        end
    end

    assign axi.BRESP_S = resp_of(err_q);
    assign axi.RRESP_S = resp_of(err_q);
`else
    assign axi.BRESP_S = RESP_OKAY;
    assign axi.RRESP_S = RESP_OKAY;
`endif

endmodule
